// File: rtl/button_debouncer.sv
// Multi-channel push-button conditioner.
// Each raw button goes through a 2-flop synchronizer and an independent
// debounce FSM. Per channel it produces a clean level plus one-cycle
// press/release pulses. All outputs come straight from flops.
module button_debouncer #(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] button_raw,
    output logic [NUM_BUTTONS-1:0] button_stable,
    output logic [NUM_BUTTONS-1:0] button_pressed,
    output logic [NUM_BUTTONS-1:0] button_released
);

    // The counter only has to reach DEBOUNCE_CYCLES-1, and it is never narrower than one bit.
    localparam int             CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } state_e;

    logic [NUM_BUTTONS-1:0] sync1_q, sync1_d;
    logic [NUM_BUTTONS-1:0] sync2_q, sync2_d;
    state_e                 state_q [NUM_BUTTONS];
    state_e                 state_d [NUM_BUTTONS];
    logic [CW-1:0]          cnt_q   [NUM_BUTTONS];
    logic [CW-1:0]          cnt_d   [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] stable_q, stable_d;
    logic [NUM_BUTTONS-1:0] pressed_q, pressed_d;
    logic [NUM_BUTTONS-1:0] released_q, released_d;

    // Next-state logic: synchronizer shift, then the per-channel debounce FSMs.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path
        // that leaves a signal unassigned would otherwise infer a latch.
        sync1_d    = button_raw;
        sync2_d    = sync1_q;
        stable_d   = stable_q;
        pressed_d  = '0;
        released_d = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                STABLE_LOW: begin
                    if (sync2_q[i]) begin
                        state_d[i] = WAIT_HIGH;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync2_q[i]) begin
                        // A glitch returns to the old level without producing a pulse.
                        state_d[i] = STABLE_LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = STABLE_HIGH;
                        cnt_d[i]     = '0;
                        stable_d[i]  = 1'b1;
                        pressed_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = WAIT_LOW;
                        cnt_d[i]   = '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync2_q[i]) begin
                        state_d[i] = STABLE_HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]    = STABLE_LOW;
                        cnt_d[i]      = '0;
                        stable_d[i]   = 1'b0;
                        released_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = STABLE_LOW;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // State registers. Reset is asynchronous and aborts any debounce in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the counters and FSM states are a few flops per channel. They
            // are reset so that a press in progress is discarded cleanly.
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= STABLE_LOW;
                cnt_q[i]   <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every flop
            // samples values from before this clock edge.
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign button_stable   = stable_q;
    assign button_pressed  = pressed_q;
    assign button_released = released_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4.
// The stimulus pushes the expected outputs for each clock edge into a
// queue, and a monitor pops and compares one entry per edge.
// With raw held from sampling edge 1, the commit lands on edge D+3 = 7.
module tb_button_debouncer;

    localparam int N = 2;
    localparam int D = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] button_raw = '0;
    logic [N-1:0] button_stable;
    logic [N-1:0] button_pressed;
    logic [N-1:0] button_released;

    button_debouncer #(
        .NUM_BUTTONS     (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .button_raw      (button_raw),
        .button_stable   (button_stable),
        .button_pressed  (button_pressed),
        .button_released (button_released)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [N-1:0] st;
        logic [N-1:0] pr;
        logic [N-1:0] rl;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           vectors     = 0;
    int           miscompares = 0;
    int           edge_no     = 0;
    logic [N-1:0] exp_stable  = '0;
    logic         rst_drive   = 1'b0;

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Hold raw for n edges. If commit_at is nonzero, the edge with that index
    // (counted from 1 within this call) is where the commit is expected.
    task automatic run(input logic [N-1:0] raw, input int n, input int commit_at,
                       input logic [N-1:0] rise, input logic [N-1:0] fall);
        exp_t e;
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            reset      = rst_drive;
            button_raw = raw;
            e.pr = '0;
            e.rl = '0;
            if (i == commit_at) begin
                exp_stable = (exp_stable | rise) & ~fall;
                e.pr = rise;
                e.rl = fall;
            end
            e.st = exp_stable;
            exp_q.push_back(e);
        end
    endtask

    // Assert reset in the middle of a cycle, then check that the outputs clear with no clock edge.
    task automatic async_reset(input string tag);
        @(posedge clock);
        #3;
        reset      = 1'b1;
        rst_drive  = 1'b1;
        exp_stable = '0;
        #1;
        check({tag, "_stable"},   button_stable,   '0);
        check({tag, "_pressed"},  button_pressed,  '0);
        check({tag, "_released"}, button_released, '0);
    endtask

    // Monitor: on each edge that has an entry queued, compare all three outputs.
    always @(posedge clock) begin
        #1;
        edge_no++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check($sformatf("stable@%0d", edge_no),   button_stable,   mon_e.st);
            check($sformatf("pressed@%0d", edge_no),  button_pressed,  mon_e.pr);
            check($sformatf("released@%0d", edge_no), button_released, mon_e.rl);
        end
    end

    initial begin
        // Reset state before any clock edge.
        #1;
        reset     = 1'b1;
        rst_drive = 1'b1;
        #1;
        check("por_stable",   button_stable,   '0);
        check("por_pressed",  button_pressed,  '0);
        check("por_released", button_released, '0);

        // 1. Reset, then idle.
        run(2'b00, 3, 0, 2'b00, 2'b00);
        rst_drive = 1'b0;
        run(2'b00, 20, 0, 2'b00, 2'b00);

        // 2. Clean press and clean release on channel 0.
        run(2'b01, 10, 7, 2'b01, 2'b00);
        run(2'b00, 10, 7, 2'b00, 2'b01);

        // 3. Glitch rejection on channel 1: a 3-cycle pulse, then a D-cycle pulse.
        run(2'b10, 3, 0, 2'b00, 2'b00);
        run(2'b00, 8, 0, 2'b00, 2'b00);
        run(2'b10, D, 0, 2'b00, 2'b00);
        run(2'b00, 8, 0, 2'b00, 2'b00);
        // A (D+1)-cycle pulse is the shortest excursion that is accepted. The rise
        // commits 7 edges after the first high sample. The fall commits 7 edges
        // after the first low sample, which is edge 6.
        run(2'b10, D + 1, 0, 2'b00, 2'b00);
        run(2'b00, 2, 2, 2'b10, 2'b00);
        run(2'b00, 8, 5, 2'b00, 2'b10);

        // 4. Bounce train on channel 0: 1,0,1,1,0,1, then held at 1.
        run(2'b01, 1, 0, 2'b00, 2'b00);
        run(2'b00, 1, 0, 2'b00, 2'b00);
        run(2'b01, 2, 0, 2'b00, 2'b00);
        run(2'b00, 1, 0, 2'b00, 2'b00);
        run(2'b01, 10, 7, 2'b01, 2'b00);
        run(2'b00, 10, 7, 2'b00, 2'b01);

        // 5. Both channels change together, then channel 1 changes alone.
        run(2'b11, 10, 7, 2'b11, 2'b00);
        run(2'b01, 10, 7, 2'b00, 2'b10);
        run(2'b00, 10, 7, 2'b00, 2'b01);

        // 6. Reset while channel 0 is in WAIT_HIGH, then re-debounce from scratch.
        run(2'b01, 5, 0, 2'b00, 2'b00);
        async_reset("rst_wait");
        run(2'b01, 3, 0, 2'b00, 2'b00);
        rst_drive = 1'b0;
        run(2'b01, 10, 7, 2'b01, 2'b00);

        // Reset while channel 0 is stable high must clear the level asynchronously.
        run(2'b01, 3, 0, 2'b00, 2'b00);
        async_reset("rst_high");
        run(2'b01, 2, 0, 2'b00, 2'b00);
        rst_drive = 1'b0;
        run(2'b00, 10, 0, 2'b00, 2'b00);

        // Give the monitor a bounded number of edges to drain the queue.
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clock);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: observed %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
